ccc_phase_ctrl: RTL and testbench
=================================

CCC_PHASE_CTRL -- requirements
Module: ccc_phase_ctrl

Interface
REQ-001 Parameter PWRDN_CYCLES, default 16: PLL powerdown hold time, in CLK cycles, ≥1.
REQ-002 Parameter LOCK_TIMEOUT, default 4095: maximum WAIT_LOCK dwell, in cycles, before the PLL is re-cycled.
REQ-003 Parameter ROT_HI_CYCLES, default 2: PHASE_ROTATE high width, ≥1.
REQ-004 Parameter ROT_GAP_CYCLES, default 4: PHASE_ROTATE low gap between steps, ≥1.
REQ-005 Port CLK, in, 1: single clock; all logic is on its rising edge.
REQ-006 Port RESET, in, 1: synchronous, active-high.
REQ-007 Port PLL_LOCK, in, 1: PLL lock, asynchronous to CLK.
REQ-008 Port PLL_RESTART, in, 1: one-cycle pulse that forces a PLL power cycle.
REQ-009 Port REQ_VALID, in, 1: phase-shift request is valid.
REQ-010 Port REQ_READY, out, 1: controller accepts a request.
REQ-011 Port REQ_SEL, in, 3: output select; bit0=OUT0, bit1=OUT2, bit2=OUT3; multiple bits allowed.
REQ-012 Port REQ_DIR, in, 1: shift direction; 1=advance, 0=retard.
REQ-013 Port REQ_STEPS, in, 8: number of rotate steps, 0..255.
REQ-014 Ports PHASE_OUT0_SEL, PHASE_OUT2_SEL, PHASE_OUT3_SEL, out, 1 each: to PLL.
REQ-015 Port PHASE_DIRECTION, out, 1: to PLL.
REQ-016 Port PHASE_ROTATE, out, 1: to PLL.
REQ-017 Port LOAD_PHASE_N, out, 1: to PLL, active low.
REQ-018 Port PLL_POWERDOWN_N, out, 1: to PLL, active low.
REQ-019 Port LOCKED, out, 1: synchronized lock, qualified by state.
REQ-020 Port BUSY, out, 1: a request is in progress.
REQ-021 Port DONE, out, 1: one-cycle pulse on request completion.
REQ-022 Port ERR_LOCK_LOST, out, 1: sticky flag; lock fell while active.
REQ-023 Port STEPS_LEFT, out, 8: remaining steps of the current request.

Function
REQ-024 PLL_LOCK SHALL pass through a 2-flop synchronizer; the synchronized signal is lock_s, and all lock decisions use lock_s only.
REQ-025 The FSM SHALL have the states PWRDN, WAIT_LOCK, IDLE, SETUP, ROT_HI, ROT_GAP, LOAD and FINISH.
REQ-026 PWRDN: PLL_POWERDOWN_N=0 for exactly PWRDN_CYCLES cycles, then WAIT_LOCK; PLL_POWERDOWN_N=1 in all other states.
REQ-027 WAIT_LOCK: lock_s=1 -> IDLE; dwell counter reaching LOCK_TIMEOUT without lock -> PWRDN.
REQ-028 IDLE: REQ_READY=1 only in IDLE and only while lock_s=1.
REQ-029 IDLE handshake: REQ_VALID&REQ_READY captures REQ_SEL, REQ_DIR and REQ_STEPS.
- REQ_STEPS=0 -> FINISH.
- REQ_STEPS≠0 -> SETUP.
REQ-030 REQ_SEL=000 with REQ_STEPS≠0 SHALL be treated as REQ_STEPS=0: no rotation, DONE only.
REQ-031 SETUP, 1 cycle: PHASE_OUTx_SEL and PHASE_DIRECTION driven from the captured request; PHASE_ROTATE=0.
REQ-032 From SETUP through LOAD, PHASE_OUTx_SEL and PHASE_DIRECTION SHALL stay stable.
REQ-033 ROT_HI: PHASE_ROTATE=1 for ROT_HI_CYCLES cycles; STEPS_LEFT decrements by 1 on exit; then ROT_GAP.
REQ-034 ROT_GAP: PHASE_ROTATE=0 for ROT_GAP_CYCLES cycles; then STEPS_LEFT≠0 -> ROT_HI, STEPS_LEFT=0 -> LOAD.
REQ-035 LOAD: LOAD_PHASE_N=0 for exactly 1 cycle, otherwise 1; then FINISH.
REQ-036 FINISH: DONE=1 for 1 cycle, then IDLE.
REQ-037 Latency, accept to DONE, for N≥1 steps: 1 + N·(ROT_HI_CYCLES+ROT_GAP_CYCLES) + 2 cycles.
REQ-038 Latency, accept to DONE, for N=0: 1 cycle.
REQ-039 BUSY=1 in SETUP, ROT_HI, ROT_GAP, LOAD and FINISH.
REQ-040 LOCKED = lock_s AND the state is not PWRDN or WAIT_LOCK.
REQ-041 Lock loss: lock_s=0 in any of IDLE, SETUP, ROT_HI, ROT_GAP or LOAD SHALL:
- set ERR_LOCK_LOST;
- abort the request with no DONE and no LOAD pulse;
- force PHASE_ROTATE=0 and PHASE_OUTx_SEL=0 next cycle;
- go to WAIT_LOCK.
REQ-042 ERR_LOCK_LOST SHALL be cleared only by RESET or by the next accepted request.
REQ-043 PLL_RESTART in any state SHALL abort any request as in REQ-041 but leave ERR_LOCK_LOST unchanged, then go to PWRDN. PLL_RESTART takes priority over lock loss and over a same-cycle handshake.
REQ-044 A request arriving while not in IDLE SHALL stall: REQ_READY=0, nothing is captured, and REQ_VALID is held by the requester.

Reset
REQ-045 RESET has priority over all other inputs.
REQ-046 RESET -> state PWRDN; all counters 0; synchronizer flops 0.
REQ-047 Output values during and after RESET:
- PLL_POWERDOWN_N=0, LOAD_PHASE_N=1;
- PHASE_ROTATE=0, PHASE_OUTx_SEL=0, PHASE_DIRECTION=0;
- REQ_READY=0, BUSY=0, DONE=0, LOCKED=0, ERR_LOCK_LOST=0, STEPS_LEFT=0.
REQ-048 RESET asserted mid-request SHALL abort the request with no DONE pulse.

Verification
REQ-049 Power-up: release RESET with PLL_LOCK=1 -> PLL_POWERDOWN_N low for 16 cycles, LOCKED=1 3 cycles after entering WAIT_LOCK, then REQ_READY=1.
REQ-050 Shift: SEL=010, DIR=1, STEPS=3 -> three PHASE_ROTATE pulses of 2 cycles each with 4-cycle gaps, PHASE_OUT2_SEL=1 throughout, one LOAD_PHASE_N low cycle, DONE 21 cycles after accept.
REQ-051 Zero steps: STEPS=0 -> no PHASE_ROTATE, no LOAD, DONE the next cycle.
REQ-052 Lock loss: drop PLL_LOCK during the second ROT_HI -> PHASE_ROTATE=0, ERR_LOCK_LOST=1, no DONE, state WAIT_LOCK; restoring lock -> REQ_READY=1.
REQ-053 Timeout: PLL_LOCK held 0 -> PLL_POWERDOWN_N re-pulses every 16+4096 cycles.
REQ-054 Restart priority: PLL_RESTART in the same cycle as a handshake -> request not captured, PWRDN entered, ERR_LOCK_LOST unchanged.

Source files
------------

// File: rtl/ccc_phase_ctrl.sv
// Phase-shift sequencer for a CCC PLL. It power-cycles the PLL until lock,
// then accepts phase-shift requests. Each step is one PHASE_ROTATE pulse on
// the selected outputs, and the sequence ends with a LOAD_PHASE_N strobe.
// A lock loss or a restart aborts any request in flight.
module ccc_phase_ctrl #(
  parameter int PWRDN_CYCLES   = 16,
  parameter int LOCK_TIMEOUT   = 4095,
  parameter int ROT_HI_CYCLES  = 2,
  parameter int ROT_GAP_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PLL_LOCK,
  input  logic       PLL_RESTART,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [2:0] REQ_SEL,
  input  logic       REQ_DIR,
  input  logic [7:0] REQ_STEPS,
  output logic       PHASE_OUT0_SEL,
  output logic       PHASE_OUT2_SEL,
  output logic       PHASE_OUT3_SEL,
  output logic       PHASE_DIRECTION,
  output logic       PHASE_ROTATE,
  output logic       LOAD_PHASE_N,
  output logic       PLL_POWERDOWN_N,
  output logic       LOCKED,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR_LOCK_LOST,
  output logic [7:0] STEPS_LEFT
);

  localparam int MAX_A   = (PWRDN_CYCLES > LOCK_TIMEOUT) ? PWRDN_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B   = (ROT_HI_CYCLES > ROT_GAP_CYCLES) ? ROT_HI_CYCLES : ROT_GAP_CYCLES;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PWRDN_LAST   = CNT_W'(PWRDN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] HI_LAST      = CNT_W'(ROT_HI_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(ROT_GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    PWRDN, WAIT_LOCK, IDLE, SETUP, ROT_HI, ROT_GAP, LOAD, FINISH
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       steps_left;
  logic [2:0]       sel_q;
  logic             dir_q;
  logic             err;
  logic             lock_p0;
  logic             lock_p1;
  logic             lock_s;
  logic             lock_lost;
  logic             accept;
  logic             drive_sel;

  assign lock_s = lock_p1;

  // Lock synchronizer; held clear while the PLL is powered down so a stale
  // lock from before the power cycle can never be taken as a fresh one.
  always_ff @(posedge CLK) begin
    if (RESET || state == PWRDN) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      lock_p0 <= PLL_LOCK;
      lock_p1 <= lock_p0;
    end
  end

  // Event decode shared by the state register and the request registers.
  always_comb begin
    lock_lost = ~lock_s && (state inside {IDLE, SETUP, ROT_HI, ROT_GAP, LOAD});
    accept    = REQ_VALID && REQ_READY;
  end

  // State register and dwell counter; the counter restarts on every state change.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= PWRDN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (PLL_RESTART || state_nxt != state) begin
        cnt <= '0;
      end else if (state inside {PWRDN, WAIT_LOCK, ROT_HI, ROT_GAP}) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Next-state logic: restart beats lock loss, which beats the normal flow.
  always_comb begin
    state_nxt = state;
    if (PLL_RESTART) begin
      state_nxt = PWRDN;
    end else if (lock_lost) begin
      state_nxt = WAIT_LOCK;
    end else begin
      case (state)
        PWRDN:     if (cnt == PWRDN_LAST) state_nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s)                    state_nxt = IDLE;
          else if (cnt == TIMEOUT_LAST)  state_nxt = PWRDN;
        end
        IDLE: begin
          if (accept) begin
            state_nxt = (REQ_STEPS == 8'd0 || REQ_SEL == 3'd0) ? FINISH : SETUP;
          end
        end
        SETUP:     state_nxt = ROT_HI;
        ROT_HI:    if (cnt == HI_LAST) state_nxt = ROT_GAP;
        ROT_GAP: begin
          if (cnt == GAP_LAST) state_nxt = (steps_left == 8'd0) ? LOAD : ROT_HI;
        end
        LOAD:      state_nxt = FINISH;
        FINISH:    state_nxt = IDLE;
        default:   state_nxt = PWRDN;
      endcase
    end
  end

  // Captured request, remaining-step count and the sticky lock-loss flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      steps_left <= 8'd0;
      sel_q      <= 3'd0;
      dir_q      <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (PLL_RESTART || lock_lost) begin
        steps_left <= 8'd0;
      end else if (accept) begin
        steps_left <= (REQ_SEL == 3'd0) ? 8'd0 : REQ_STEPS;
      end else if (state == ROT_HI && cnt == HI_LAST) begin
        steps_left <= steps_left - 8'd1;
      end
      if (accept) begin
        sel_q <= REQ_SEL;
        dir_q <= REQ_DIR;
      end
      if (!PLL_RESTART) begin
        if (lock_lost)   err <= 1'b1;
        else if (accept) err <= 1'b0;
      end
    end
  end

  // Output decode; strobes are gated so an aborting cycle never emits them.
  always_comb begin
    drive_sel       = state inside {SETUP, ROT_HI, ROT_GAP, LOAD};
    PHASE_OUT0_SEL  = drive_sel & sel_q[0];
    PHASE_OUT2_SEL  = drive_sel & sel_q[1];
    PHASE_OUT3_SEL  = drive_sel & sel_q[2];
    PHASE_DIRECTION = drive_sel & dir_q;
    PHASE_ROTATE    = (state == ROT_HI);
    LOAD_PHASE_N    = ~((state == LOAD) & lock_s & ~PLL_RESTART);
    PLL_POWERDOWN_N = (state != PWRDN);
    REQ_READY       = (state == IDLE) & lock_s & ~PLL_RESTART;
    LOCKED          = lock_s & (state != PWRDN) & (state != WAIT_LOCK);
    BUSY            = state inside {SETUP, ROT_HI, ROT_GAP, LOAD, FINISH};
    DONE            = (state == FINISH) & ~PLL_RESTART;
    ERR_LOCK_LOST   = err;
    STEPS_LEFT      = steps_left;
  end

endmodule

// File: tb/tb_ccc_phase_ctrl.sv
// Bench for ccc_phase_ctrl: scoreboard of expected transactions, compared
// against what a monitor observes on the PLL-side pins at each DONE.
module tb_ccc_phase_ctrl;

  localparam int HI  = 2;
  localparam int GAP = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       PLL_LOCK = 1'b0;
  logic       PLL_RESTART = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic [2:0] REQ_SEL = 3'd0;
  logic       REQ_DIR = 1'b0;
  logic [7:0] REQ_STEPS = 8'd0;
  logic       PHASE_OUT0_SEL, PHASE_OUT2_SEL, PHASE_OUT3_SEL;
  logic       PHASE_DIRECTION, PHASE_ROTATE, LOAD_PHASE_N, PLL_POWERDOWN_N;
  logic       LOCKED, BUSY, DONE, ERR_LOCK_LOST;
  logic [7:0] STEPS_LEFT;

  ccc_phase_ctrl dut (
    .CLK(CLK), .RESET(RESET), .PLL_LOCK(PLL_LOCK), .PLL_RESTART(PLL_RESTART),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_SEL(REQ_SEL),
    .REQ_DIR(REQ_DIR), .REQ_STEPS(REQ_STEPS),
    .PHASE_OUT0_SEL(PHASE_OUT0_SEL), .PHASE_OUT2_SEL(PHASE_OUT2_SEL),
    .PHASE_OUT3_SEL(PHASE_OUT3_SEL), .PHASE_DIRECTION(PHASE_DIRECTION),
    .PHASE_ROTATE(PHASE_ROTATE), .LOAD_PHASE_N(LOAD_PHASE_N),
    .PLL_POWERDOWN_N(PLL_POWERDOWN_N), .LOCKED(LOCKED), .BUSY(BUSY),
    .DONE(DONE), .ERR_LOCK_LOST(ERR_LOCK_LOST), .STEPS_LEFT(STEPS_LEFT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] lat;
    logic [7:0]  pulses;
    logic [7:0]  hi;
    logic [7:0]  loads;
    logic [2:0]  sel;
    logic        dir;
    logic        unstable;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_total = 0;
  int   load_total = 0;
  int   acc_cyc = 0;
  bit   in_txn = 0;
  bit   prev_rot = 0;
  bit   seen_rot = 0;
  txn_t cur = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: builds one observed record per request, from accept to DONE.
  always @(negedge CLK) begin
    if (RESET) begin
      in_txn   = 0;
      prev_rot = 0;
    end else begin
      if (REQ_VALID && REQ_READY) begin
        in_txn   = 1;
        acc_cyc  = cyc;
        cur      = '0;
        seen_rot = 0;
      end
      if (PHASE_ROTATE) begin
        if (!prev_rot) cur.pulses = cur.pulses + 8'd1;
        cur.hi = cur.hi + 8'd1;
        if (seen_rot && ({PHASE_OUT3_SEL, PHASE_OUT2_SEL, PHASE_OUT0_SEL} != cur.sel ||
                         PHASE_DIRECTION != cur.dir))
          cur.unstable = 1'b1;
        cur.sel  = {PHASE_OUT3_SEL, PHASE_OUT2_SEL, PHASE_OUT0_SEL};
        cur.dir  = PHASE_DIRECTION;
        seen_rot = 1;
      end
      if (!LOAD_PHASE_N) begin
        cur.loads  = cur.loads + 8'd1;
        load_total = load_total + 1;
      end
      if (DONE) begin
        done_total = done_total + 1;
        cur.lat = 16'(cyc - acc_cyc);
        if (in_txn) obs_q.push_back(cur);
        in_txn = 0;
      end
      prev_rot = PHASE_ROTATE;
    end
  end

  function automatic txn_t mk(input int n, input logic [2:0] sel, input logic dir);
    txn_t t;
    t.lat      = 16'((n == 0) ? 1 : 1 + n * (HI + GAP) + 2);
    t.pulses   = 8'(n);
    t.hi       = 8'(n * HI);
    t.loads    = 8'((n == 0) ? 0 : 1);
    t.sel      = (n == 0) ? 3'b000 : sel;
    t.dir      = (n == 0) ? 1'b0 : dir;
    t.unstable = 1'b0;
    return t;
  endfunction

  task automatic issue(input logic [2:0] sel, input logic dir, input logic [7:0] steps,
                       output bit ok);
    @(posedge CLK); #1;
    REQ_SEL = sel; REQ_DIR = dir; REQ_STEPS = steps; REQ_VALID = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (REQ_READY) begin ok = 1; break; end
    end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (obs_q.size() >= n) begin ok = 1; break; end
      @(negedge CLK);
    end
  endtask

  task automatic wait_ready(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (REQ_READY) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    logic [19:0] got;
    RESET = 1'b1; PLL_LOCK = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    got = {PLL_POWERDOWN_N, LOAD_PHASE_N, PHASE_ROTATE, PHASE_OUT3_SEL, PHASE_OUT2_SEL,
           PHASE_OUT0_SEL, PHASE_DIRECTION, REQ_READY, BUSY, DONE, LOCKED, ERR_LOCK_LOST,
           STEPS_LEFT};
    n_cmp++;
    if (got !== {1'b0, 1'b1, 10'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required %b", got, {1'b0, 1'b1, 10'b0, 8'd0});
    end
  endtask

  task automatic test_powerup();
    int n_low = 0;
    int n_wait = 0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (PLL_POWERDOWN_N) break;
      n_low++;
    end
    n_cmp++;
    if (n_low != 16) begin
      n_fail++; $display("FAIL powerup_pwrdn_len: got %0d required 16", n_low);
    end
    for (int i = 0; i < 50; i++) begin
      if (LOCKED) break;
      @(negedge CLK);
      n_wait++;
    end
    n_cmp++;
    if (n_wait != 3) begin
      n_fail++; $display("FAIL powerup_lock_delay: got %0d required 3", n_wait);
    end
    n_cmp++;
    if (REQ_READY !== 1'b1) begin
      n_fail++; $display("FAIL powerup_ready: got %b required 1", REQ_READY);
    end
  endtask

  task automatic test_shift();
    logic [2:0] sels[3]  = '{3'b010, 3'b101, 3'b111};
    logic       dirs[3]  = '{1'b1, 1'b0, 1'b1};
    int         steps[3] = '{3, 1, 2};
    logic [13:0] setup_v;
    txn_t e, o;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(steps[k], sels[k], dirs[k]));
      issue(sels[k], dirs[k], 8'(steps[k]), ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL shift%0d_accept: got no REQ_READY required 1", k); end
      if (k == 0) begin
        @(negedge CLK);
        setup_v = {BUSY, PHASE_ROTATE, PHASE_OUT3_SEL, PHASE_OUT2_SEL, PHASE_OUT0_SEL,
                   PHASE_DIRECTION, STEPS_LEFT};
        n_cmp++;
        if (setup_v !== {1'b1, 1'b0, 3'b010, 1'b1, 8'd3}) begin
          n_fail++;
          $display("FAIL shift_setup: got %b required %b", setup_v, {1'b1, 1'b0, 3'b010, 1'b1, 8'd3});
        end
      end
      wait_obs(1, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok) begin
        n_fail++; $display("FAIL shift%0d_done: got no DONE required lat %0d", k, e.lat);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL shift%0d_txn: got lat=%0d pulses=%0d hi=%0d loads=%0d sel=%b dir=%b unst=%b required lat=%0d pulses=%0d hi=%0d loads=%0d sel=%b dir=%b unst=%b",
                   k, o.lat, o.pulses, o.hi, o.loads, o.sel, o.dir, o.unstable,
                   e.lat, e.pulses, e.hi, e.loads, e.sel, e.dir, e.unstable);
        end
      end
    end
    @(negedge CLK);
    n_cmp++;
    if ({ERR_LOCK_LOST, BUSY, REQ_READY, STEPS_LEFT} !== {3'b001, 8'd0}) begin
      n_fail++;
      $display("FAIL shift_idle: got err=%b busy=%b ready=%b steps=%0d required 0 0 1 0",
               ERR_LOCK_LOST, BUSY, REQ_READY, STEPS_LEFT);
    end
  endtask

  task automatic test_zero_steps();
    logic [2:0] sels[2]  = '{3'b001, 3'b000};
    int         steps[2] = '{0, 5};
    txn_t e, o;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(0, sels[k], 1'b1));
      issue(sels[k], 1'b1, 8'(steps[k]), ok);
      wait_obs(1, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok) begin
        n_fail++; $display("FAIL zero%0d_done: got no DONE required lat 1", k);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL zero%0d_txn: got lat=%0d pulses=%0d loads=%0d sel=%b required lat=%0d pulses=%0d loads=%0d sel=%b",
                   k, o.lat, o.pulses, o.loads, o.sel, e.lat, e.pulses, e.loads, e.sel);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    txn_t e, o;
    bit ok;
    exp_q.push_back(mk(1, 3'b001, 1'b1));
    exp_q.push_back(mk(2, 3'b100, 1'b0));
    @(posedge CLK); #1;
    REQ_SEL = 3'b001; REQ_DIR = 1'b1; REQ_STEPS = 8'd1; REQ_VALID = 1'b1;
    wait_ready(50, ok);
    @(posedge CLK); #1;
    REQ_SEL = 3'b100; REQ_DIR = 1'b0; REQ_STEPS = 8'd2;
    @(negedge CLK);
    n_cmp++;
    if (REQ_READY !== 1'b0 || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL b2b_stall: got ready=%b busy=%b required 0 1", REQ_READY, BUSY);
    end
    wait_ready(100, ok);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    wait_obs(2, ok);
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL b2b%0d_done: got no DONE required lat %0d", k, e.lat);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL b2b%0d_txn: got lat=%0d pulses=%0d loads=%0d sel=%b dir=%b required lat=%0d pulses=%0d loads=%0d sel=%b dir=%b",
                   k, o.lat, o.pulses, o.loads, o.sel, o.dir, e.lat, e.pulses, e.loads, e.sel, e.dir);
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    int done0, load0;
    logic [14:0] v;
    bit ok;
    done0 = done_total; load0 = load_total;
    issue(3'b010, 1'b1, 8'd3, ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (PHASE_ROTATE && cur.pulses == 8'd2) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL lockloss_second_pulse: got none required 1"); end
    PLL_LOCK = 1'b0;
    repeat (6) @(negedge CLK);
    v = {PHASE_ROTATE, PHASE_OUT3_SEL, PHASE_OUT2_SEL, PHASE_OUT0_SEL, PHASE_DIRECTION,
         BUSY, LOCKED, REQ_READY, PLL_POWERDOWN_N, ERR_LOCK_LOST, STEPS_LEFT[4:0]};
    n_cmp++;
    if (v !== {8'b0000_0000, 1'b1, 1'b1, 5'd0}) begin
      n_fail++; $display("FAIL lockloss_state: got %b required %b", v, {8'b0, 2'b11, 5'd0});
    end
    n_cmp++;
    if (done_total != done0 || load_total != load0) begin
      n_fail++;
      $display("FAIL lockloss_no_done_load: got done=%0d load=%0d required done=%0d load=%0d",
               done_total, load_total, done0, load0);
    end
    PLL_LOCK = 1'b1;
    wait_ready(50, ok);
    n_cmp++;
    if (!ok || ERR_LOCK_LOST !== 1'b1) begin
      n_fail++; $display("FAIL lockloss_recover: got ready=%b err=%b required 1 1", ok, ERR_LOCK_LOST);
    end
  endtask

  task automatic test_restart();
    int done0 = done_total;
    int n_low = 0;
    bit ok;
    @(posedge CLK); #1;
    REQ_SEL = 3'b010; REQ_DIR = 1'b1; REQ_STEPS = 8'd3; REQ_VALID = 1'b1; PLL_RESTART = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (REQ_READY !== 1'b0) begin
      n_fail++; $display("FAIL restart_ready: got %b required 0", REQ_READY);
    end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; PLL_RESTART = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({PLL_POWERDOWN_N, BUSY, ERR_LOCK_LOST} !== 3'b001) begin
      n_fail++;
      $display("FAIL restart_state: got pdn=%b busy=%b err=%b required 0 0 1",
               PLL_POWERDOWN_N, BUSY, ERR_LOCK_LOST);
    end
    for (int i = 0; i < 100; i++) begin
      if (PLL_POWERDOWN_N) break;
      n_low++;
      @(negedge CLK);
    end
    n_cmp++;
    if (n_low != 16) begin
      n_fail++; $display("FAIL restart_pwrdn_len: got %0d required 16", n_low);
    end
    wait_ready(50, ok);
    n_cmp++;
    if (!ok || done_total != done0 || ERR_LOCK_LOST !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_after: got ready=%b dones=%0d err=%b required 1 %0d 1",
               ok, done_total - done0, ERR_LOCK_LOST, 0);
    end
  endtask

  task automatic test_err_clear();
    txn_t e, o;
    bit ok;
    exp_q.push_back(mk(0, 3'b001, 1'b0));
    issue(3'b001, 1'b0, 8'd0, ok);
    @(negedge CLK);
    n_cmp++;
    if (ERR_LOCK_LOST !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got %b required 0", ERR_LOCK_LOST);
    end
    wait_obs(1, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok) begin
      n_fail++; $display("FAIL err_clear_done: got no DONE required lat 1");
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin
        n_fail++; $display("FAIL err_clear_txn: got lat=%0d loads=%0d required lat=%0d loads=%0d",
                           o.lat, o.loads, e.lat, e.loads);
      end
    end
  endtask

  task automatic test_reset_mid();
    int done0 = done_total;
    logic [15:0] v;
    bit ok;
    issue(3'b010, 1'b1, 8'd3, ok);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (PHASE_ROTATE) break;
    end
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    v = {BUSY, PHASE_ROTATE, PLL_POWERDOWN_N, LOAD_PHASE_N, DONE, ERR_LOCK_LOST,
         PHASE_OUT3_SEL, PHASE_OUT2_SEL, STEPS_LEFT};
    n_cmp++;
    if (v !== {8'b0001_0000, 8'd0}) begin
      n_fail++; $display("FAIL reset_mid_state: got %b required %b", v, {8'b0001_0000, 8'd0});
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (40) @(negedge CLK);
    n_cmp++;
    if (done_total != done0) begin
      n_fail++; $display("FAIL reset_mid_no_done: got %0d required %0d", done_total, done0);
    end
  endtask

  task automatic test_timeout();
    int t0, t1;
    int n_low = 0;
    bit ok = 0;
    PLL_LOCK = 1'b0;
    @(posedge CLK); #1;
    PLL_RESTART = 1'b1;
    @(posedge CLK); #1;
    PLL_RESTART = 1'b0;
    @(negedge CLK);
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      if (PLL_POWERDOWN_N) break;
      n_low++;
      @(negedge CLK);
    end
    n_cmp++;
    if (n_low != 16) begin
      n_fail++; $display("FAIL timeout_pwrdn_len: got %0d required 16", n_low);
    end
    t1 = t0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLK);
      if (!PLL_POWERDOWN_N) begin ok = 1; t1 = cyc; break; end
      if (REQ_READY || LOCKED) ok = 0;
    end
    n_cmp++;
    if (!ok || (t1 - t0) != 16 + 4096) begin
      n_fail++; $display("FAIL timeout_period: got %0d required %0d", t1 - t0, 16 + 4096);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish required finish before 1ms");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_powerup();
    test_shift();
    test_zero_steps();
    test_back_to_back();
    test_lock_loss();
    test_restart();
    test_err_clear();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
